dmem_arbiter: RTL
=================

# dmem_arbiter

Shares the single-port data RAM between the pipeline MEM stage and an external requester (debug loader or future DMA). The MEM stage has fixed priority. The external port gets every idle RAM cycle. A starvation counter guarantees the external port is served: when it expires, the block forces a one-cycle pipeline freeze through the hazard unit. The block sits between the EX/MEM register outputs and the data RAM.

## Interface
- STARVE_MAX, 8: consecutive denied cycles before a forced grant (legal range 1–255).
- clk  in  1  main pipeline clock (debug-gated clock in the core).
- rst  in  1  synchronous, active-high reset.
- cpu_req  in  1  MEM stage accesses RAM this cycle.
- cpu_we  in  1  MEM stage write.
- cpu_addr  in  32  MEM byte address.
- cpu_wdata  in  32  MEM store data.
- cpu_ubhw  in  3  MEM width/sign code (funct3).
- cpu_rdata  out  32  read data to MEM stage / forwarding muxes.
- cpu_hold  out  1  registered; freezes every pipeline register enable and PC for one cycle.
- ext_req, ext_we  in  1  external request and write flag.
- ext_addr, ext_wdata  in  32  external address and store data.
- ext_ubhw  in  3  external width code.
- ext_gnt  out  1  combinational grant; the access completes this cycle.
- ext_rvalid  out  1  registered; pulses the cycle after a granted read.
- ext_rdata  out  32  registered read data; valid with ext_rvalid.
- ram_addr, ram_wdata  out  32  RAM address and write data.
- ram_we  out  1  RAM write enable.
- ram_ubhw  out  3  RAM width code.
- ram_rdata  in  32  RAM read data, combinational from ram_addr.

## Operation
**States**
- CPU (default): cpu_hold=0.
- FORCE: cpu_hold=1.

**Grant and muxing**
- ext_gnt = ext_req & (cpu_hold | ~cpu_req).
- When ext_gnt=1, the RAM mux selects the ext_* signals. Otherwise it selects cpu_*.
- ram_we is masked: cpu_we & cpu_req in CPU owner, ext_we in EXT owner.
- cpu_rdata = ram_rdata at all times. Its value is don't-care during FORCE.

**Starvation counter** (8 bits, cnt)
- Cleared when ext_req=0 or ext_gnt=1.
- Increments on ext_req & ~ext_gnt, saturating at STARVE_MAX.
- If cnt == STARVE_MAX-1 and the current cycle is denied, the next state is FORCE.
- FORCE always returns to CPU after exactly one cycle, with cnt=0. cpu_hold is therefore never high for two consecutive cycles.

**Read return**
- On a granted read (ext_gnt & ~ext_we), ext_rdata <= ram_rdata and ext_rvalid <= 1.
- Otherwise ext_rvalid <= 0 and ext_rdata holds its value.

**External protocol**
- ext_* must stay stable from ext_req rise until ext_gnt.
- ext_req may stay high for back-to-back accesses; each grant cycle is one access.

**Pipeline side**
- While cpu_hold=1, the hazard unit deasserts all stage enables.
- The MEM instruction re-presents cpu_req the next cycle and is serviced then.
- The block does not buffer CPU requests.

**Reset**
- All outputs 0: cpu_hold, ext_rvalid, ext_rdata=0. cnt=0, state=CPU.
- Reset mid-FORCE or with a pending read return drops both immediately; no pulse follows reset.

## Timing
- Idle grant: zero added latency. ext_gnt is in the same cycle as ext_req when cpu_req=0.
- Read data: ext_rvalid/ext_rdata arrive 1 cycle after the grant cycle.
- Worst-case external wait: exactly STARVE_MAX denied cycles, then the grant in the FORCE cycle.
- Pipeline cost: one frozen cycle per forced grant.
- Simultaneous cpu_req and ext_req in CPU state: CPU wins and cnt increments.
- ext_req dropped before grant: cnt clears and no FORCE occurs. If FORCE is already scheduled, it still occurs for one cycle with no access (ram_we=0).
- STARVE_MAX=1: FORCE follows any single denied cycle.

## Structure
- Package dmem_arb_pkg: state encoding (CPU=1'b0, FORCE=1'b1), ubhw width constants (byte/half/word, signed/unsigned), and the counter width.
- One sub-module, dmem_arb_starve_ctr: clear/increment/saturate counter with expire output.
- The top level holds the FSM, muxes and read-return register.

## Test plan
- Idle grant: cpu_req=0; ext read at 0x40, RAM word 0xDEADBEEF → ext_gnt same cycle; ext_rvalid=1 with ext_rdata=0xDEADBEEF next cycle; cpu_hold stays 0.
- Starvation: cpu_req=1 continuously; ext write 0x12345678 to 0x80 at cycle 0, STARVE_MAX=8 → denied cycles 0–7; cpu_hold=1 and ext_gnt=1 at cycle 8 with ram_we=1; cpu_hold=0 at cycle 9; later CPU load of 0x80 returns 0x12345678.
- Collision: cpu store and ext store in the same cycle → only the CPU write reaches RAM (ram_addr=cpu_addr); cnt=1.
- Withdrawal: ext_req high for 5 cycles under CPU load, then low → cnt returns to 0; no cpu_hold; no ext_rvalid.
- Reset mid-operation: rst asserted in the FORCE cycle and the cycle before an expected ext_rvalid → cpu_hold=0, ext_rvalid=0, ext_rdata=0 on the next edge; the counter restarts from 0.
- Back-to-back: cpu_req=0; ext_req held for 4 reads at addresses 0x0/0x4/0x8/0xC → 4 consecutive grants; 4 consecutive ext_rvalid pulses carrying the matching data.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// rtl/dmem_arb_pkg.sv - shared types and constants for the data RAM arbiter
package dmem_arb_pkg;

    // Ownership state: CPU owns the RAM by default, FORCE steals one cycle
    typedef enum logic {
        ST_CPU   = 1'b0,
        ST_FORCE = 1'b1
    } arb_state_t;

    // Width/sign codes carried on *_ubhw (funct3 encoding)
    localparam logic [2:0] UBHW_B  = 3'b000;
    localparam logic [2:0] UBHW_H  = 3'b001;
    localparam logic [2:0] UBHW_W  = 3'b010;
    localparam logic [2:0] UBHW_BU = 3'b100;
    localparam logic [2:0] UBHW_HU = 3'b101;

    // Starvation counter width; STARVE_MAX must fit
    localparam int CNT_W = 8;

endpackage

// File: rtl/dmem_arb_starve_ctr.sv
// rtl/dmem_arb_starve_ctr.sv - clear/increment/saturate starvation counter
module dmem_arb_starve_ctr
    import dmem_arb_pkg::*;
#(
    parameter int STARVE_MAX = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt,
    output logic             expire
);

    localparam logic [CNT_W-1:0] MAX_V  = CNT_W'(STARVE_MAX);
    localparam logic [CNT_W-1:0] LAST_V = CNT_W'(STARVE_MAX - 1);

    // Count consecutive denied cycles; clear wins, saturate at STARVE_MAX
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (inc && (cnt != MAX_V)) begin
            cnt <= cnt + 1'b1;
        end
    end

    // The denied cycle that completes STARVE_MAX misses schedules a FORCE
    always_comb begin
        expire = inc && (cnt == LAST_V);
    end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - MEM stage / external requester arbiter for the data RAM
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int STARVE_MAX = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic [2:0]  cpu_ubhw,
    output logic [31:0] cpu_rdata,
    output logic        cpu_hold,
    input  logic        ext_req,
    input  logic        ext_we,
    input  logic [31:0] ext_addr,
    input  logic [31:0] ext_wdata,
    input  logic [2:0]  ext_ubhw,
    output logic        ext_gnt,
    output logic        ext_rvalid,
    output logic [31:0] ext_rdata,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_wdata,
    output logic        ram_we,
    output logic [2:0]  ram_ubhw,
    input  logic [31:0] ram_rdata
);

    arb_state_t       state_q;
    arb_state_t       state_d;
    logic             denied;
    logic             expire;
    logic [CNT_W-1:0] starve_cnt;

    dmem_arb_starve_ctr #(
        .STARVE_MAX (STARVE_MAX)
    ) u_starve_ctr (
        .clk    (clk),
        .rst    (rst),
        .clr    (~ext_req | ext_gnt),
        .inc    (denied),
        .cnt    (starve_cnt),
        .expire (expire)
    );

    // Grant is combinational so an idle RAM cycle costs the requester nothing
    always_comb begin
        cpu_hold = (state_q == ST_FORCE);
        ext_gnt  = ext_req & (cpu_hold | ~cpu_req);
        denied   = ext_req & ~ext_gnt;
    end

    // RAM mux; a FORCE cycle with no external access must not replay a CPU store
    always_comb begin
        cpu_rdata = ram_rdata;
        if (ext_gnt) begin
            ram_addr  = ext_addr;
            ram_wdata = ext_wdata;
            ram_ubhw  = ext_ubhw;
            ram_we    = ext_we;
        end else begin
            ram_addr  = cpu_addr;
            ram_wdata = cpu_wdata;
            ram_ubhw  = cpu_ubhw;
            ram_we    = cpu_we & cpu_req & ~cpu_hold;
        end
    end

    // FSM next state: FORCE lasts exactly one cycle
    always_comb begin
        state_d = ST_CPU;
        if ((state_q == ST_CPU) && expire) begin
            state_d = ST_FORCE;
        end
    end

    // FSM state register; doubles as the registered cpu_hold
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_CPU;
        end else begin
            state_q <= state_d;
        end
    end

    // Read return: capture RAM data on a granted external read
    always_ff @(posedge clk) begin
        if (rst) begin
            ext_rvalid <= 1'b0;
            ext_rdata  <= '0;
        end else if (ext_gnt && !ext_we) begin
            ext_rvalid <= 1'b1;
            ext_rdata  <= ram_rdata;
        end else begin
            ext_rvalid <= 1'b0;
        end
    end

endmodule
